// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types, widths and helpers for the round-robin channel arbiter.
package rr_mux_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int HOLD_CNT_W = 8;
    localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = 8'd255;

    // Index width never collapses to zero, even for tiny requester counts.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr,
// wrapping around past the top index.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    logic [IDX_W-1:0] cand_s;

    // Scan offsets 0..NREQ-1 from ptr and latch onto the first requester found.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NREQ);
            if (!any && req[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
            end
        end
        if (any) begin
            onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer locking a shared output channel to one requester
// per packet. Optional hold limit enabled by macro ARB_HOLD_LIMIT_EN.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0]                 last,
    input  logic [NREQ*DW-1:0]              data_in,
    input  logic                            out_ready,
    output logic [NREQ-1:0]                 grant,
    output logic [idx_width(NREQ)-1:0]      sel,
    output logic                            out_valid,
    output logic [DW-1:0]                   out_data,
    output logic                            forced_rel
);

    localparam int IDX_W = idx_width(NREQ);

    arb_state_t             state_q, state_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [HOLD_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic                   forced_rel_q, forced_rel_d;

    logic                   pick_any_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [NREQ-1:0]        pick_onehot_s;
    logic                   beat_s;
    logic                   rel_last_s;
    logic                   rel_drop_s;
    logic                   rel_limit_s;
    logic [HOLD_CNT_W-1:0]  hold_inc_s;
    logic [IDX_W-1:0]       ptr_next_s;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    assign out_valid  = (state_q == ARB_GRANT) && req[sel_q];
    assign out_data   = data_in[int'(sel_q)*DW +: DW];
    assign grant      = grant_q;
    assign sel        = sel_q;
    assign forced_rel = forced_rel_q;

    assign beat_s     = out_valid && out_ready;
    assign rel_last_s = beat_s && last[sel_q];
    assign rel_drop_s = !req[sel_q];
    assign hold_inc_s = (hold_cnt_q == HOLD_CNT_MAX) ? hold_cnt_q : hold_cnt_q + 8'd1;
    assign ptr_next_s = (sel_q == IDX_W'(NREQ-1)) ? '0 : sel_q + IDX_W'(1);

`ifdef ARB_HOLD_LIMIT_EN
    assign rel_limit_s = beat_s && (hold_inc_s == HOLD_CNT_W'(MAX_HOLD));
`else
    logic [HOLD_CNT_W-1:0] unused_max_hold_s;
    assign unused_max_hold_s = HOLD_CNT_W'(MAX_HOLD);
    assign rel_limit_s       = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, count beats and detect release in GRANT.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        forced_rel_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_d    = ARB_GRANT;
                    grant_d    = pick_onehot_s;
                    sel_d      = pick_idx_s;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (beat_s) begin
                    hold_cnt_d = hold_inc_s;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
                // last outranks the hold limit, so a coincident end-of-packet is not "forced".
                if (rel_last_s || rel_drop_s || rel_limit_s) begin
                    state_d      = ARB_IDLE;
                    grant_d      = '0;
                    ptr_d        = ptr_next_s;
                    forced_rel_d = rel_limit_s && !rel_last_s;
                end else begin
                    state_d = ARB_GRANT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            sel_q        <= '0;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            forced_rel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            forced_rel_q <= forced_rel_d;
        end
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for a shared DW-bit output channel fed by NREQ requesters. It selects one requester at a time and locks the channel to it for a packet, terminated by `last`, request drop or a hold limit. It drives the channel-select mux and presents the selected data on a valid/ready output. It sits between the requester front-ends and the single downstream consumer.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DW`, default 4: data width per requester.
- `MAX_HOLD`, default 8: maximum accepted beats per grant, 1..255. Only used with `ARB_HOLD_LIMIT_EN`.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous and active-high.
- `req` input NREQ: per-requester request / beat-valid.
- `last` input NREQ: per-requester end-of-packet flag, qualified by a beat transfer.
- `data_in` input NREQ*DW: requester i occupies bits [i*DW +: DW].
- `out_ready` input 1: downstream accepts a beat.
- `grant` output NREQ: one-hot owner, all-zero when idle.
- `sel` output clog2(NREQ): owner index, registered. Holds the last owner when idle.
- `out_valid` output 1: `req[owner]` while in GRANT, otherwise 0.
- `out_data` output DW: `data_in` slice of the owner, combinational from `sel`.
- `forced_rel` output 1: single-cycle pulse when the hold limit ends a grant.

## Operation
- **FSM states.** IDLE and GRANT. The state, `sel`, `grant`, the rotation pointer `ptr` and the beat counter `hold_cnt` are registers.
- **Reset values.** State IDLE, `grant`=0, `sel`=0, `ptr`=0, `hold_cnt`=0, `forced_rel`=0.
  - Consequently `out_valid`=0 and `out_data` = `data_in[DW-1:0]`.
- **IDLE.**
  - If `req` is non-zero, the winner is the first set bit searching upward from `ptr` with wrap-around.
  - The next state is GRANT with `grant`=onehot(winner), `sel`=winner and `hold_cnt`=0.
  - If `req` is zero, the FSM stays in IDLE.
- **GRANT.**
  - A beat is the condition `out_valid && out_ready`.
  - Each beat increments `hold_cnt`, which saturates at 255.
- **Release conditions.** Any one of the following moves GRANT back to IDLE:
  - (a) a beat with `last[sel]`=1;
  - (b) `req[sel]`=0, a request drop with no beat;
  - (c) with `ARB_HOLD_LIMIT_EN` only, a beat that makes `hold_cnt` equal `MAX_HOLD`. This sets `forced_rel` for one cycle.
- **Effects of release.** `ptr` becomes (sel+1) mod NREQ, `grant` becomes 0 and `sel` holds.
- **Simultaneous release causes.** If (a) and (c) occur together, `forced_rel` stays 0; `last` has priority.
- **No fabricated beats.** The arbiter never generates beats. Data is passed through unchanged.
- **Other requesters.** Requests other than the owner's are ignored during GRANT.

## Timing
- **Grant latency.** `req` asserted in cycle N while IDLE gives `grant`/`sel` valid and `out_valid` high in cycle N+1.
- **Re-arbitration gap.** Release in cycle M puts the FSM in IDLE in cycle M+1, with a new grant at the earliest in M+2. Every grant switch therefore has one dead cycle.
- **Throughput.** Up to one beat per cycle within a grant. `out_ready` low stalls with no loss, and `hold_cnt` does not advance during a stall.
- **Hold limit.** The MAX_HOLD-th beat is accepted. Release follows in the same cycle's update.
- **Mid-operation reset.** Asserting `rst` clears all state immediately. Any in-flight packet is abandoned, and there is no partial-beat output.
- **Fairness.** A continuously requesting requester waits at most (NREQ-1) grants.

## Configuration
- **Macro `ARB_HOLD_LIMIT_EN`.**
- **When defined.** Release condition (c) is active and `forced_rel` pulses as specified.
- **When undefined.** The owner keeps the channel until `last` or a drop. `forced_rel` is tied to 0. The `hold_cnt` comparison logic is not compiled; the counter may be removed.
- `MAX_HOLD` is ignored when the macro is undefined.

## Structure
- **Package `rr_mux_arbiter_pkg`.**
  - `arb_state_t` enum {ARB_IDLE, ARB_GRANT}.
  - `HOLD_CNT_W`=8.
  - A function computing the index width as max(1, clog2(NREQ)).
- **Sub-module `rr_pick`.** A combinational rotate-priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `any`, `idx`, `onehot`.
  - It is instantiated once and tested standalone for all `ptr`/`req` combinations at NREQ=4.

## Test plan
- **Reset then single request.** `rst` pulse, then `req`=4'b0100 with `out_ready`=1 and `last` set on beat 3.
  - Expect `grant`=0100 and `sel`=2 one cycle after `req`.
  - Expect exactly 3 beats of `data_in[11:8]`, then IDLE.
- **Round-robin rotation.** `req`=4'b1111 held, each requester sending 1-beat packets with `last`=1.
  - Expect the grant order 0,1,2,3,0 with one idle cycle between grants.
- **Backpressure.** `out_ready` toggled 1,0,0,1 during a 2-beat packet from requester 1.
  - Expect `out_data` to hold while stalled and `hold_cnt` to be unchanged.
  - Expect release only after the second accepted beat.
- **Hold limit** (`ARB_HOLD_LIMIT_EN`, MAX_HOLD=8). Requester 0 streams without `last`.
  - Expect release after beat 8 with a one-cycle `forced_rel` pulse.
  - Expect the next grant to go to requester 1 if it is requesting.
  - Without the macro, expect no release through 20 beats.
- **Request drop and `last` priority.**
  - Owner 3 drops `req` mid-packet: expect IDLE next cycle and `ptr`=0.
  - `last` on beat 8 with the limit enabled: expect `forced_rel`=0.
- **Asynchronous reset mid-grant.** Assert `rst` between clock edges during GRANT.
  - Expect `grant`=0 and `out_valid`=0 immediately.
  - Expect `ptr`=0 after reset, so requester 0 wins first.
